// File: rtl/mcu_lsu.sv
// Load/store unit: single outstanding op, valid/ready data-memory bus, aligned/extended load writeback.
// Optional misalignment trap enabled by defining MCU_LSU_MISALIGN_FAULT_EN.
module mcu_lsu #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_is_store,
  input  logic [1:0]    req_size,
  input  logic          req_unsigned,
  input  logic [AW-1:0] req_addr,
  input  logic [DW-1:0] req_wdata,
  input  logic [4:0]    req_rd,
  output logic          dmem_req_valid,
  input  logic          dmem_req_ready,
  output logic          dmem_we,
  output logic [AW-1:0] dmem_addr,
  output logic [3:0]    dmem_wstrb,
  output logic [DW-1:0] dmem_wdata,
  input  logic          dmem_rsp_valid,
  input  logic [DW-1:0] dmem_rsp_data,
  output logic          lsu_wb_valid,
  output logic [4:0]    lsu_wb_rd,
  output logic [DW-1:0] lsu_wb_data,
  output logic          busy,
  output logic [4:0]    busy_rd,
  output logic          lsu_fault_valid,
  output logic [AW-1:0] lsu_fault_addr
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  state_t        r_state;
  state_t        w_next;
  logic          r_is_store;
  logic [1:0]    r_size;
  logic          r_unsigned;
  logic [AW-1:0] r_addr;
  logic [3:0]    r_wstrb;
  logic [DW-1:0] r_wdata;
  logic [4:0]    r_rd;
  logic          r_wb_valid;
  logic [4:0]    r_wb_rd;
  logic [DW-1:0] r_wb_data;

  logic          w_misalign;
  logic          w_accept;
  logic [3:0]    w_wstrb;
  logic [DW-1:0] w_wdata;
  logic [DW-1:0] w_shb;
  logic [DW-1:0] w_shh;
  logic [DW-1:0] w_ld;

`ifdef MCU_LSU_MISALIGN_FAULT_EN
  logic          r_fault_valid;
  logic [AW-1:0] r_fault_addr;

  always_comb begin
    w_misalign = ((req_size == 2'd1) && req_addr[0]) ||
                 (req_size[1] && (req_addr[1:0] != 2'b00));
  end

  // Misaligned ops are trapped at accept and never reach the bus.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fault_valid <= 1'b0;
      r_fault_addr  <= '0;
    end else begin
      r_fault_valid <= (r_state == IDLE) && req_valid && w_misalign;
      if ((r_state == IDLE) && req_valid && w_misalign)
        r_fault_addr <= req_addr;
    end
  end

  assign lsu_fault_valid = r_fault_valid;
  assign lsu_fault_addr  = r_fault_addr;
`else
  always_comb begin
    w_misalign = 1'b0;
  end

  assign lsu_fault_valid = 1'b0;
  assign lsu_fault_addr  = '0;
`endif

  assign w_accept = (r_state == IDLE) && req_valid && !w_misalign;

  always_comb begin
    w_wstrb = 4'b1111;
    w_wdata = req_wdata;
    case (req_size)
      2'd0: begin
        w_wstrb = 4'b0001 << req_addr[1:0];
        w_wdata = {4{req_wdata[7:0]}};
      end
      2'd1: begin
        w_wstrb = 4'b0011 << {req_addr[1], 1'b0};
        w_wdata = {2{req_wdata[15:0]}};
      end
      default: begin
        w_wstrb = 4'b1111;
        w_wdata = req_wdata;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: if (w_accept) w_next = REQ;
      REQ:  if (dmem_req_ready) w_next = r_is_store ? IDLE : WAIT;
      WAIT: if (dmem_rsp_valid) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_is_store <= 1'b0;
      r_size     <= '0;
      r_unsigned <= 1'b0;
      r_addr     <= '0;
      r_wstrb    <= '0;
      r_wdata    <= '0;
      r_rd       <= '0;
    end else if (w_accept) begin
      r_is_store <= req_is_store;
      r_size     <= req_size;
      r_unsigned <= req_unsigned;
      r_addr     <= req_addr;
      r_wstrb    <= w_wstrb;
      r_wdata    <= w_wdata;
      r_rd       <= req_rd;
    end
  end

  // Shift the addressed lane down to bit 0 before extending.
  always_comb begin
    w_shb = dmem_rsp_data >> {r_addr[1:0], 3'b000};
    w_shh = dmem_rsp_data >> {r_addr[1], 4'b0000};
    case (r_size)
      2'd0:    w_ld = r_unsigned ? {24'b0, w_shb[7:0]}  : {{24{w_shb[7]}}, w_shb[7:0]};
      2'd1:    w_ld = r_unsigned ? {16'b0, w_shh[15:0]} : {{16{w_shh[15]}}, w_shh[15:0]};
      default: w_ld = dmem_rsp_data;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wb_valid <= 1'b0;
      r_wb_rd    <= '0;
      r_wb_data  <= '0;
    end else begin
      r_wb_valid <= 1'b0;
      if ((r_state == WAIT) && dmem_rsp_valid && (r_rd != 5'd0)) begin
        r_wb_valid <= 1'b1;
        r_wb_rd    <= r_rd;
        r_wb_data  <= w_ld;
      end
    end
  end

  assign req_ready      = (r_state == IDLE);
  assign dmem_req_valid = (r_state == REQ);
  assign dmem_we        = (r_state == REQ) && r_is_store;
  assign dmem_addr      = {r_addr[AW-1:2], 2'b00};
  assign dmem_wstrb     = r_wstrb;
  assign dmem_wdata     = r_wdata;
  assign lsu_wb_valid   = r_wb_valid;
  assign lsu_wb_rd      = r_wb_rd;
  assign lsu_wb_data    = r_wb_data;
  assign busy           = (r_state != IDLE);
  assign busy_rd        = ((r_state != IDLE) && !r_is_store) ? r_rd : 5'd0;

endmodule

// File: tb/tb_mcu_lsu.sv
// Scoreboard bench for mcu_lsu: stimulus queues expected bus/writeback/fault events, a monitor checks them.
module tb_mcu_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_is_store, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic [4:0]  req_rd;
  logic        dmem_req_valid, dmem_req_ready, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rsp_data;
  logic [3:0]  dmem_wstrb;
  logic        dmem_rsp_valid;
  logic        lsu_wb_valid, busy, lsu_fault_valid;
  logic [4:0]  lsu_wb_rd, busy_rd;
  logic [31:0] lsu_wb_data, lsu_fault_addr;

  mcu_lsu #(.AW(32), .DW(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_is_store(req_is_store),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_rd(req_rd),
    .dmem_req_valid(dmem_req_valid), .dmem_req_ready(dmem_req_ready), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_wstrb(dmem_wstrb), .dmem_wdata(dmem_wdata),
    .dmem_rsp_valid(dmem_rsp_valid), .dmem_rsp_data(dmem_rsp_data),
    .lsu_wb_valid(lsu_wb_valid), .lsu_wb_rd(lsu_wb_rd), .lsu_wb_data(lsu_wb_data),
    .busy(busy), .busy_rd(busy_rd),
    .lsu_fault_valid(lsu_fault_valid), .lsu_fault_addr(lsu_fault_addr)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
  } bus_t;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } wb_t;

  bus_t        exp_bus[$];
  wb_t         exp_wb[$];
  logic [31:0] exp_fault[$];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic unexpected(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: DUT event with empty expectation queue at %0t", name, $time);
  endtask

  bus_t        m_bus;
  wb_t         m_wb;
  logic [31:0] m_fa;

  always @(negedge clk) begin
    if (!rst) begin
      if (dmem_req_valid && dmem_req_ready) begin
        if (exp_bus.size() == 0) unexpected("bus_unexpected");
        else begin
          m_bus = exp_bus.pop_front();
          check("bus_we", {31'b0, dmem_we}, {31'b0, m_bus.we});
          check("bus_addr", dmem_addr, m_bus.addr);
          if (m_bus.we) begin
            check("bus_wstrb", {28'b0, dmem_wstrb}, {28'b0, m_bus.wstrb});
            check("bus_wdata", dmem_wdata, m_bus.wdata);
          end
        end
      end
      if (lsu_wb_valid) begin
        if (exp_wb.size() == 0) unexpected("wb_unexpected");
        else begin
          m_wb = exp_wb.pop_front();
          check("wb_rd", {27'b0, lsu_wb_rd}, {27'b0, m_wb.rd});
          check("wb_data", lsu_wb_data, m_wb.data);
        end
      end
      if (lsu_fault_valid) begin
        if (exp_fault.size() == 0) unexpected("fault_unexpected");
        else begin
          m_fa = exp_fault.pop_front();
          check("fault_addr", lsu_fault_addr, m_fa);
        end
      end
    end
  end

  task automatic issue(input logic st, input logic [1:0] sz, input logic un,
                       input logic [31:0] a, input logic [31:0] wd, input logic [4:0] rd);
    @(posedge clk); #1;
    req_valid = 1'b1; req_is_store = st; req_size = sz; req_unsigned = un;
    req_addr = a; req_wdata = wd; req_rd = rd;
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic do_store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd,
                          input logic [3:0] strb, input logic [31:0] wdat);
    exp_bus.push_back('{we: 1'b1, addr: a & ~32'h3, wstrb: strb, wdata: wdat});
    issue(1'b1, sz, 1'b0, a, wd, 5'd0);
    @(negedge clk);
    check("st_req_valid", {31'b0, dmem_req_valid}, 32'd1);
    check("st_req_ready_low", {31'b0, req_ready}, 32'd0);
    @(negedge clk);
    check("st_ready_back", {31'b0, req_ready}, 32'd1);
    check("st_req_done", {31'b0, dmem_req_valid}, 32'd0);
  endtask

  task automatic do_load(input logic [1:0] sz, input logic un, input logic [31:0] a,
                         input logic [4:0] rd, input logic [31:0] rsp, input logic [31:0] exp_d);
    exp_bus.push_back('{we: 1'b0, addr: a & ~32'h3, wstrb: 4'b0, wdata: 32'b0});
    if (rd != 5'd0) exp_wb.push_back('{rd: rd, data: exp_d});
    issue(1'b0, sz, un, a, 32'h0, rd);
    @(negedge clk);
    check("ld_req_c1", {31'b0, dmem_req_valid}, 32'd1);
    check("ld_busy_rd", {27'b0, busy_rd}, {27'b0, rd});
    @(posedge clk); #1;
    dmem_rsp_valid = 1'b1; dmem_rsp_data = rsp;
    @(negedge clk);
    check("ld_wb_c2", {31'b0, lsu_wb_valid}, 32'd0);
    check("ld_busy_c2", {31'b0, busy}, 32'd1);
    @(posedge clk); #1;
    dmem_rsp_valid = 1'b0; dmem_rsp_data = 32'h0;
    @(negedge clk);
    check("ld_wb_c3", {31'b0, lsu_wb_valid}, {31'b0, (rd != 5'd0)});
    check("ld_ready_c3", {31'b0, req_ready}, 32'd1);
    check("ld_busy_rd_idle", {27'b0, busy_rd}, 32'd0);
    @(negedge clk);
    check("ld_wb_pulse", {31'b0, lsu_wb_valid}, 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_ready"}, {31'b0, req_ready}, 32'd1);
    check({tag, "_dmem_valid"}, {31'b0, dmem_req_valid}, 32'd0);
    check({tag, "_dmem_we"}, {31'b0, dmem_we}, 32'd0);
    check({tag, "_dmem_addr"}, dmem_addr, 32'd0);
    check({tag, "_dmem_wstrb"}, {28'b0, dmem_wstrb}, 32'd0);
    check({tag, "_dmem_wdata"}, dmem_wdata, 32'd0);
    check({tag, "_wb_valid"}, {31'b0, lsu_wb_valid}, 32'd0);
    check({tag, "_wb_rd"}, {27'b0, lsu_wb_rd}, 32'd0);
    check({tag, "_wb_data"}, lsu_wb_data, 32'd0);
    check({tag, "_busy"}, {31'b0, busy}, 32'd0);
    check({tag, "_busy_rd"}, {27'b0, busy_rd}, 32'd0);
    check({tag, "_fault"}, {31'b0, lsu_fault_valid}, 32'd0);
    check({tag, "_fault_addr"}, lsu_fault_addr, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_is_store = 1'b0; req_size = 2'd0; req_unsigned = 1'b0;
    req_addr = '0; req_wdata = '0; req_rd = '0;
    dmem_req_ready = 1'b1; dmem_rsp_valid = 1'b0; dmem_rsp_data = '0;
    repeat (2) @(negedge clk);
    check_reset_outputs("rst");
    @(posedge clk); #1;
    rst = 1'b0;

    do_store(2'd0, 32'h0000_1003, 32'h0000_00AB, 4'b1000, 32'hABAB_ABAB);
    do_store(2'd1, 32'h0000_1002, 32'h1234_ABCD, 4'b1100, 32'hABCD_ABCD);
    do_store(2'd2, 32'h0000_1004, 32'hDEAD_BEEF, 4'b1111, 32'hDEAD_BEEF);
    do_store(2'd0, 32'h0000_1000, 32'h0000_00C5, 4'b0001, 32'hC5C5_C5C5);
    do_store(2'd3, 32'h0000_1008, 32'h0102_0304, 4'b1111, 32'h0102_0304);

    do_load(2'd0, 1'b0, 32'h0000_2001, 5'd7, 32'h0000_80FF, 32'hFFFF_FF80);
    do_load(2'd2, 1'b0, 32'h0000_2000, 5'd0, 32'hFFFF_FFFF, 32'h0);
    check("rd0_hold_rd", {27'b0, lsu_wb_rd}, 32'd7);
    check("rd0_hold_data", lsu_wb_data, 32'hFFFF_FF80);
    do_load(2'd1, 1'b1, 32'h0000_2002, 5'd3, 32'hBEEF_1234, 32'h0000_BEEF);
    do_load(2'd1, 1'b0, 32'h0000_2002, 5'd4, 32'hBEEF_1234, 32'hFFFF_BEEF);
    do_load(2'd0, 1'b1, 32'h0000_2003, 5'd12, 32'h80FF_1234, 32'h0000_0080);
    do_load(2'd1, 1'b0, 32'h0000_2000, 5'd13, 32'hBEEF_7234, 32'h0000_7234);

    // Bus stalls five cycles in REQ; handshake on the sixth.
    dmem_req_ready = 1'b0;
    exp_bus.push_back('{we: 1'b0, addr: 32'h0000_3000, wstrb: 4'b0, wdata: 32'b0});
    exp_wb.push_back('{rd: 5'd9, data: 32'hCAFE_F00D});
    issue(1'b0, 2'd2, 1'b0, 32'h0000_3000, 32'h0, 5'd9);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_valid", {31'b0, dmem_req_valid}, 32'd1);
      check("stall_addr", dmem_addr, 32'h0000_3000);
      check("stall_we", {31'b0, dmem_we}, 32'd0);
      check("stall_req_ready", {31'b0, req_ready}, 32'd0);
      check("stall_busy", {31'b0, busy}, 32'd1);
      check("stall_busy_rd", {27'b0, busy_rd}, 32'd9);
    end
    @(posedge clk); #1;
    dmem_req_ready = 1'b1;
    @(negedge clk);
    check("stall_hs_valid", {31'b0, dmem_req_valid}, 32'd1);
    @(posedge clk); #1;
    dmem_rsp_valid = 1'b1; dmem_rsp_data = 32'hCAFE_F00D;
    @(posedge clk); #1;
    dmem_rsp_valid = 1'b0;
    @(negedge clk);
    check("stall_wb_valid", {31'b0, lsu_wb_valid}, 32'd1);
    check("stall_idle", {31'b0, busy}, 32'd0);

    // Reset while waiting for load data; late response must be dropped.
    exp_bus.push_back('{we: 1'b0, addr: 32'h0000_4000, wstrb: 4'b0, wdata: 32'b0});
    issue(1'b0, 2'd2, 1'b0, 32'h0000_4000, 32'h0, 5'd5);
    @(negedge clk);
    @(posedge clk); #1;
    check("wait_busy_pre_rst", {31'b0, busy}, 32'd1);
    rst = 1'b1;
    #1;
    check_reset_outputs("midrst");
    dmem_rsp_valid = 1'b1; dmem_rsp_data = 32'h5555_5555;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("late_rsp_no_wb", {31'b0, lsu_wb_valid}, 32'd0);
    check("late_rsp_idle", {31'b0, busy}, 32'd0);
    @(posedge clk); #1;
    dmem_rsp_valid = 1'b0;
    @(negedge clk);
    check("late_rsp_no_wb2", {31'b0, lsu_wb_valid}, 32'd0);
    do_load(2'd2, 1'b0, 32'h0000_4004, 5'd21, 32'h1357_9BDF, 32'h1357_9BDF);

`ifdef MCU_LSU_MISALIGN_FAULT_EN
    exp_fault.push_back(32'h0000_2002);
    issue(1'b0, 2'd2, 1'b0, 32'h0000_2002, 32'h0, 5'd3);
    @(negedge clk);
    check("mis_fault_pulse", {31'b0, lsu_fault_valid}, 32'd1);
    check("mis_no_bus", {31'b0, dmem_req_valid}, 32'd0);
    check("mis_idle", {31'b0, busy}, 32'd0);
    @(negedge clk);
    check("mis_fault_1cyc", {31'b0, lsu_fault_valid}, 32'd0);
`else
    do_load(2'd2, 1'b0, 32'h0000_2002, 5'd3, 32'h1122_3344, 32'h1122_3344);
    check("mis_no_fault", {31'b0, lsu_fault_valid}, 32'd0);
`endif

    repeat (2) @(negedge clk);
    check("sb_bus_drained", exp_bus.size(), 32'd0);
    check("sb_wb_drained", exp_wb.size(), 32'd0);
    check("sb_fault_drained", exp_fault.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
